// File: rtl/register_chain_pipeline.sv
// ---------------------------------------------------------------------------
// register_chain_pipeline
//
// A DEPTH-stage register chain that carries a WIDTH-bit word and a valid bit
// per stage. Data entering stage k may be bitwise inverted, selected per stage
// by INVERT_MASK[k]. The chain advances on CE, and FLUSH drops every in-flight
// entry. A registered OCCUPANCY count tracks how many stages hold valid data.
//
// Parameters
//   WIDTH        data width in bits (>= 1)
//   DEPTH        number of register stages (>= 1)
//   INVERT_MASK  per-stage inversion select, bit k applies to data entering k
//   INIT         reset value of every data stage
//
// Ports
//   CLK        in   1                   clock, rising edge
//   RESET      in   1                   synchronous active-high reset
//   I0         in   WIDTH               data into stage 0
//   I0_valid   in   1                   qualifies I0
//   CE         in   1                   advance enable (0 = stall)
//   FLUSH      in   1                   invalidate all in-flight entries
//   O0         out  WIDTH               stage DEPTH-1 data register
//   O0_valid   out  1                   stage DEPTH-1 valid bit
//   OCCUPANCY  out  $clog2(DEPTH+1)     number of valid stages
// ---------------------------------------------------------------------------
module register_chain_pipeline #(
  parameter int                 WIDTH       = 1,
  parameter int                 DEPTH       = 2,
  parameter logic [DEPTH-1:0]   INVERT_MASK = 2'b10,
  parameter logic [WIDTH-1:0]   INIT        = '0
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [WIDTH-1:0]             I0,
  input  logic                         I0_valid,
  input  logic                         CE,
  input  logic                         FLUSH,
  output logic [WIDTH-1:0]             O0,
  output logic                         O0_valid,
  output logic [$clog2(DEPTH+1)-1:0]   OCCUPANCY
);

  localparam int                OCC_W   = $clog2(DEPTH + 1);
  localparam logic [OCC_W:0]    OCC_MAX = (OCC_W + 1)'(DEPTH);
  localparam logic [OCC_W:0]    OCC_ONE = (OCC_W + 1)'(1);

  // Stage k data and valid; index DEPTH-1 is the output stage.
  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] vld_p;
  logic [OCC_W-1:0] occ_p;

  // Conditional bitwise inversion applied to the word entering a stage.
  function automatic logic [WIDTH-1:0] stage_in(input logic [WIDTH-1:0] d,
                                                input logic             inv);
    return inv ? ~d : d;
  endfunction

  // Occupancy step: add the entry accepted at stage 0, retire the one leaving
  // the output stage. Clamped to 0..DEPTH so the count can never wrap.
  function automatic logic [OCC_W-1:0] occ_update(input logic [OCC_W-1:0] cur,
                                                  input logic             add,
                                                  input logic             sub);
    logic [OCC_W:0] acc;
    acc = {1'b0, cur} + {{OCC_W{1'b0}}, add};
    if (sub && (acc != '0)) acc = acc - OCC_ONE;
    if (acc > OCC_MAX) acc = OCC_MAX;
    return acc[OCC_W-1:0];
  endfunction

  // Data stages: advance on CE regardless of valid bits or FLUSH.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < DEPTH; k++) data_p[k] <= INIT;
    end else if (CE) begin
      data_p[0] <= stage_in(I0, INVERT_MASK[0]);
      for (int k = 1; k < DEPTH; k++) data_p[k] <= stage_in(data_p[k-1], INVERT_MASK[k]);
    end
  end

  // Control stages: valid bits and occupancy. FLUSH wins over CE and also
  // drops the entry being offered on I0 in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p <= '0;
      occ_p <= '0;
    end else if (FLUSH) begin
      vld_p <= '0;
      occ_p <= '0;
    end else if (CE) begin
      vld_p[0] <= I0_valid;
      for (int k = 1; k < DEPTH; k++) vld_p[k] <= vld_p[k-1];
      occ_p <= occ_update(occ_p, I0_valid, vld_p[DEPTH-1]);
    end
  end

  // Outputs come straight from registers.
  assign O0        = data_p[DEPTH-1];
  assign O0_valid  = vld_p[DEPTH-1];
  assign OCCUPANCY = occ_p;

endmodule

// File: tb/tb_register_chain_pipeline.sv
// ---------------------------------------------------------------------------
// tb_register_chain_pipeline
//
// Two instances: an 8-bit, 3-stage chain with mask 3'b010, and the default
// 1-bit, 2-stage chain. Stimulus pushes expected output words into a queue
// per instance; a negedge monitor per instance pops and compares whenever
// O0_valid is high. Occupancy, reset state and timing are checked directly.
// ---------------------------------------------------------------------------
module tb_register_chain_pipeline;

  logic real_clk;

  // 8-bit / 3-stage instance
  logic       m_rst, m_vld, m_ce, m_flush;
  logic [7:0] m_i0;
  logic [7:0] m_o0;
  logic       m_o0_vld;
  logic [1:0] m_occ;

  // default instance
  logic       d_rst, d_vld, d_ce, d_flush;
  logic [0:0] d_i0;
  logic [0:0] d_o0;
  logic       d_o0_vld;
  logic [1:0] d_occ;

  int checks = 0;
  int passed = 0;

  logic [7:0] q_m [$];
  logic [0:0] q_d [$];

  register_chain_pipeline #(
    .WIDTH(8), .DEPTH(3), .INVERT_MASK(3'b010), .INIT(8'h00)
  ) u_main (
    .CLK(real_clk), .RESET(m_rst), .I0(m_i0), .I0_valid(m_vld),
    .CE(m_ce), .FLUSH(m_flush), .O0(m_o0), .O0_valid(m_o0_vld),
    .OCCUPANCY(m_occ)
  );

  register_chain_pipeline u_dflt (
    .CLK(real_clk), .RESET(d_rst), .I0(d_i0), .I0_valid(d_vld),
    .CE(d_ce), .FLUSH(d_flush), .O0(d_o0), .O0_valid(d_o0_vld),
    .OCCUPANCY(d_occ)
  );

  initial begin
    real_clk = 1'b0;
    forever #5 real_clk = ~real_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge real_clk);
    #1;
  endtask

  // Scoreboard monitors
  always @(negedge real_clk) begin
    if (m_o0_vld === 1'b1) begin
      if (q_m.size() == 0) begin
        checks++;
        $display("FAIL main_unexpected_out: got %0h, expected no valid output (t=%0t)", m_o0, $time);
      end else begin
        check("main_out", {24'd0, m_o0}, {24'd0, q_m.pop_front()});
      end
    end
  end

  always @(negedge real_clk) begin
    if (d_o0_vld === 1'b1) begin
      if (q_d.size() == 0) begin
        checks++;
        $display("FAIL dflt_unexpected_out: got %0h, expected no valid output (t=%0t)", d_o0, $time);
      end else begin
        check("dflt_out", {31'd0, d_o0}, {31'd0, q_d.pop_front()});
      end
    end
  end

  // Drive one accepted word into the 8-bit chain; expected output is ~x
  // because only stage 1 inverts.
  task automatic m_send(input logic [7:0] x);
    m_i0  = x;
    m_vld = 1'b1;
    m_ce  = 1'b1;
    q_m.push_back(~x);
  endtask

  localparam int N32 = 5;
  logic [7:0] occ_fill  [N32] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
  logic [7:0] occ_drain [3]   = '{8'd2, 8'd1, 8'd0};

  initial begin
    m_rst = 1'b1; m_vld = 1'b0; m_ce = 1'b0; m_flush = 1'b0; m_i0 = 8'h00;
    d_rst = 1'b1; d_vld = 1'b0; d_ce = 1'b0; d_flush = 1'b0; d_i0 = 1'b0;
    step();
    step();
    m_rst = 1'b0;
    d_rst = 1'b0;

    // Reset state
    check("rst_o0",      {24'd0, m_o0}, 32'h00);
    check("rst_o0_vld",  {31'd0, m_o0_vld}, 32'd0);
    check("rst_occ",     {30'd0, m_occ}, 32'd0);
    check("drst_o0",     {31'd0, d_o0}, 32'd0);
    check("drst_o0_vld", {31'd0, d_o0_vld}, 32'd0);
    check("drst_occ",    {30'd0, d_occ}, 32'd0);

    // Single word, CE held high: valid after the third edge
    m_send(8'h5A);
    step();
    m_vld = 1'b0; m_i0 = 8'h00;
    check("t30_occ_e0", {30'd0, m_occ}, 32'd1);
    check("t30_vld_e0", {31'd0, m_o0_vld}, 32'd0);
    step();
    check("t30_occ_e1", {30'd0, m_occ}, 32'd1);
    check("t30_vld_e1", {31'd0, m_o0_vld}, 32'd0);
    step();
    check("t30_vld_e2", {31'd0, m_o0_vld}, 32'd1);
    check("t30_o0_e2",  {24'd0, m_o0}, 32'hA5);
    check("t30_occ_e2", {30'd0, m_occ}, 32'd1);
    step();
    check("t30_occ_e3", {30'd0, m_occ}, 32'd0);

    // Same word with a two-cycle stall mid-flight
    m_send(8'h5A);
    step();
    m_vld = 1'b0;
    step();
    m_ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("t31_occ_stall", {30'd0, m_occ}, 32'd1);
      check("t31_vld_stall", {31'd0, m_o0_vld}, 32'd0);
    end
    m_ce = 1'b1;
    step();
    check("t31_vld_late", {31'd0, m_o0_vld}, 32'd1);
    check("t31_o0_late",  {24'd0, m_o0}, 32'hA5);
    step();
    check("t31_occ_done", {30'd0, m_occ}, 32'd0);

    // Back-to-back 01..05 -> FE..FA
    for (int i = 0; i < N32; i++) begin
      m_send(8'(i + 1));
      step();
      check("t32_occ_fill", {30'd0, m_occ}, {24'd0, occ_fill[i]});
    end
    m_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t32_occ_drain", {30'd0, m_occ}, {24'd0, occ_drain[i]});
    end
    check("t32_queue_empty", q_m.size(), 32'd0);

    // Three valid entries, then FLUSH with CE low
    m_send(8'h11); step();
    m_send(8'h22); step();
    m_send(8'h33); step();
    check("t33_occ_full", {30'd0, m_occ}, 32'd3);
    m_ce = 1'b0; m_flush = 1'b1; m_i0 = 8'h44; m_vld = 1'b1;
    step();
    q_m.delete();
    check("t33_occ_flushed", {30'd0, m_occ}, 32'd0);
    check("t33_vld_flushed", {31'd0, m_o0_vld}, 32'd0);
    m_flush = 1'b0; m_vld = 1'b0; m_ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t33_vld_after", {31'd0, m_o0_vld}, 32'd0);
    end

    // RESET together with FLUSH and CE mid-stream
    m_send(8'hA1); step();
    m_send(8'hB2); step();
    check("t34_occ_before", {30'd0, m_occ}, 32'd2);
    m_rst = 1'b1; m_flush = 1'b1; m_ce = 1'b1; m_i0 = 8'hC3; m_vld = 1'b1;
    step();
    q_m.delete();
    check("t34_o0",     {24'd0, m_o0}, 32'h00);
    check("t34_o0_vld", {31'd0, m_o0_vld}, 32'd0);
    check("t34_occ",    {30'd0, m_occ}, 32'd0);
    m_rst = 1'b0; m_flush = 1'b0; m_vld = 1'b0; m_ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t34_vld_after", {31'd0, m_o0_vld}, 32'd0);
    end

    // Default chain: register, inverter, register
    d_ce = 1'b1; d_i0 = 1'b1; d_vld = 1'b1; q_d.push_back(1'b0);
    step();
    check("t35_occ_e0", {30'd0, d_occ}, 32'd1);
    d_i0 = 1'b0; d_vld = 1'b1; q_d.push_back(1'b1);
    step();
    check("t35_o0_one",  {31'd0, d_o0}, 32'd0);
    check("t35_vld_one", {31'd0, d_o0_vld}, 32'd1);
    check("t35_occ_e1",  {30'd0, d_occ}, 32'd2);
    d_vld = 1'b0; d_i0 = 1'b1;
    step();
    check("t35_o0_zero", {31'd0, d_o0}, 32'd1);
    check("t35_occ_e2",  {30'd0, d_occ}, 32'd1);
    step();
    check("t35_occ_e3",  {30'd0, d_occ}, 32'd0);
    check("t35_vld_e3",  {31'd0, d_o0_vld}, 32'd0);
    step();
    check("dflt_queue_empty", q_d.size(), 32'd0);
    check("main_queue_empty", q_m.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
